// File: rtl/alu_exec_pkg.sv
// Package: alu_exec_pkg
// Purpose: shared definitions for the ALU execution unit and the ALU decoder
//   that drives it.
// Contents:
//   ALU_ADD/ALU_SUB/ALU_MULT/ALU_LUI/ALU_SLTI : 3-bit ALU control codes
//   state_t                                   : execution FSM states
package alu_exec_pkg;

    // ALU control codes; every other 3-bit value is an illegal operation
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MULT = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b110;
    localparam logic [2:0] ALU_SLTI = 3'b111;

    // Execution FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Interface: alu_exec_unit_if
// Purpose: request/response bundle between EX-stage control and the ALU
//   execution unit.
// Signals:
//   valid_in, alu_control[2:0], a[W-1:0], b[W-1:0] : request (master -> slave)
//   ready                                          : slave can accept a request
//   valid_out, result, hi, zero, illegal, overflow : response (slave -> master)
// Modports: master (control side), slave (execution unit).
interface alu_exec_unit_if #(
    parameter int W = 32
);
    logic         valid_in;
    logic [2:0]   alu_control;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         valid_out;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         zero;
    logic         illegal;
    logic         overflow;

    modport master (
        output valid_in, alu_control, a, b,
        input  ready, valid_out, result, hi, zero, illegal, overflow
    );

    modport slave (
        input  valid_in, alu_control, a, b,
        output ready, valid_out, result, hi, zero, illegal, overflow
    );
endinterface

// File: rtl/alu_exec_unit_seq_multiplier.sv
// Module: seq_multiplier
// Purpose: iterative unsigned W x W -> 2W radix-2 shift-add multiplier.
//   One iteration per cycle. It takes W iterations after start.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : load operands and begin (ignored while busy)
//   mcand_in    : multiplicand (unsigned, W bits)
//   mplier_in   : multiplier (unsigned, W bits)
//   busy        : an iteration sequence is in progress
//   done        : iteration counter at its final value; qualify with busy
//   product     : product after the iteration performed this cycle
//                 (the full result while busy & done)
module seq_multiplier #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   mcand_in,
    input  logic [W-1:0]   mplier_in,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    logic [W-1:0]   mcand;
    logic [2*W-1:0] prod;
    logic [CNT_W-1:0] cnt;
    logic           busy_r;
    logic [W:0]     partial;

    // The upper half accumulates the partial sums. The lower half starts as the
    // multiplier and is consumed LSB-first as the register shifts right.
    // The carry bit of the add shifts into the top bit.
    always_comb begin
        partial = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
    end

    assign product = {partial, prod[W-1:1]};
    assign done    = (cnt == CNT_W'(W - 1));
    assign busy    = busy_r;

    // Operand load, then one shift-add step per cycle until the counter is
    // exhausted. The counter returns to zero so that done stays low while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
        end else if (start && !busy_r) begin
            mcand  <= mcand_in;
            prod   <= {{W{1'b0}}, mplier_in};
            cnt    <= '0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            prod <= product;
            if (done) begin
                cnt    <= '0;
                busy_r <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Module: alu_exec_unit
// Purpose: EX-stage ALU execution unit. It executes the 3-bit ALU control code
//   on two operands. add/sub/lui/slti have a latency of 1 cycle. mult runs on
//   the iterative seq_multiplier and has a latency of W+1 cycles. The unit
//   accepts one operation at a time, so at most one op completes every 2 cycles.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : alu_exec_unit_if.slave (valid_in/alu_control/a/b in;
//            ready/valid_out/result/hi/zero/illegal/overflow out)
// Configuration:
//   ALU_OVERFLOW_EN : when defined, overflow reports signed add/sub overflow.
//                     When undefined, overflow is tied to 0.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);

    state_t         state;
    logic           ready_r;
    logic           valid_r;
    logic [W-1:0]   result_r;
    logic [W-1:0]   hi_r;
    logic           zero_r;
    logic           illegal_r;
    logic           neg_r;

    logic           accept;
    logic           is_mult;
    logic           mul_start;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic           mul_busy;
    logic           mul_done;
    logic [2*W-1:0] mul_product;
    logic [2*W-1:0] signed_product;
    logic [W-1:0]   op_result;
    logic           op_illegal;

    assign accept    = ready_r & bus.valid_in;
    assign is_mult   = (bus.alu_control == ALU_MULT);
    assign mul_start = accept & is_mult;

    // The magnitude of -2^(W-1) is 2^(W-1). This value still fits in W
    // unsigned bits, so the most negative operand needs no special handling.
    assign mag_a = bus.a[W-1] ? (~bus.a + W'(1)) : bus.a;
    assign mag_b = bus.b[W-1] ? (~bus.b + W'(1)) : bus.b;

    // The sign is applied to the final product in the same cycle that it is
    // registered.
    assign signed_product = neg_r ? (~mul_product + (2*W)'(1)) : mul_product;

    seq_multiplier #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_mult (
        .clk       (clk),
        .reset     (reset),
        .start     (mul_start),
        .mcand_in  (mag_a),
        .mplier_in (mag_b),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );

    // Results of the single-cycle operations, computed from the live request.
    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        case (bus.alu_control)
            ALU_ADD:  op_result = bus.a + bus.b;
            ALU_SUB:  op_result = bus.a - bus.b;
            ALU_LUI:  op_result = {bus.b[W/2-1:0], {(W/2){1'b0}}};
            ALU_SLTI: op_result = ($signed(bus.a) < $signed(bus.b)) ? W'(1) : '0;
            ALU_MULT: op_result = '0;
            default:  op_illegal = 1'b1;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    logic op_overflow;
    logic overflow_r;

    // Signed overflow occurs when the result sign differs from the sign that
    // the operands imply.
    always_comb begin
        op_overflow = 1'b0;
        case (bus.alu_control)
            ALU_ADD: op_overflow = (bus.a[W-1] == bus.b[W-1]) && (op_result[W-1] != bus.a[W-1]);
            ALU_SUB: op_overflow = (bus.a[W-1] != bus.b[W-1]) && (op_result[W-1] != bus.a[W-1]);
            default: op_overflow = 1'b0;
        endcase
    end
`endif

    // Control FSM. ready is high only in IDLE. Requests made while the unit is
    // busy are dropped, not queued. Outputs are held after valid_out falls and
    // change only when the next operation completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            result_r  <= '0;
            hi_r      <= '0;
            zero_r    <= 1'b1;
            illegal_r <= 1'b0;
            neg_r     <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            overflow_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (accept) begin
                        ready_r <= 1'b0;
                        if (is_mult) begin
                            state <= MULT;
                            neg_r <= bus.a[W-1] ^ bus.b[W-1];
                        end else begin
                            state     <= DONE;
                            valid_r   <= 1'b1;
                            result_r  <= op_result;
                            hi_r      <= '0;
                            zero_r    <= (op_result == '0);
                            illegal_r <= op_illegal;
`ifdef ALU_OVERFLOW_EN
                            overflow_r <= op_overflow;
`endif
                        end
                    end
                end
                MULT: begin
                    if (mul_busy && mul_done) begin
                        state     <= DONE;
                        valid_r   <= 1'b1;
                        result_r  <= signed_product[W-1:0];
                        hi_r      <= signed_product[2*W-1:W];
                        zero_r    <= (signed_product[W-1:0] == '0);
                        illegal_r <= 1'b0;
`ifdef ALU_OVERFLOW_EN
                        overflow_r <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready     = ready_r;
    assign bus.valid_out = valid_r;
    assign bus.result    = result_r;
    assign bus.hi        = hi_r;
    assign bus.zero      = zero_r;
    assign bus.illegal   = illegal_r;
`ifdef ALU_OVERFLOW_EN
    assign bus.overflow  = overflow_r;
`else
    assign bus.overflow  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench: tb_alu_exec_unit
// Purpose: directed self-checking bench for alu_exec_unit (W=32). Each
//   scenario task drives its own vectors and compares the outputs with
//   hand-computed values. The expected overflow value follows ALU_OVERFLOW_EN.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    localparam int W = 32;

`ifdef ALU_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.W(W)) bus ();

    alu_exec_unit #(.W(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Waits until the unit is ready (bounded), then presents one request for
    // exactly one rising edge. Returns 1 time unit after the accept edge.
    task automatic do_op(input logic [2:0] code, input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        int waited = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if (bus.ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL ready_wait actual=%b required=1", bus.ready);
        end
        bus.valid_in = 1'b1; bus.alu_control = code; bus.a = op_a; bus.b = op_b;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    // Counts cycles from the accept edge to valid_out (bounded). Records
    // whether ready was seen high while the result was pending.
    task automatic wait_valid(output int cycles, output logic ready_seen);
        cycles = 1;
        ready_seen = 1'b0;
        while (bus.valid_out !== 1'b1 && cycles < 100) begin
            if (bus.ready !== 1'b0) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        compared++; if (bus.ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_ready actual=%b required=1", bus.ready); end
        compared++; if (bus.valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid actual=%b required=0", bus.valid_out); end
        compared++; if (bus.result !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_result actual=%h required=0", bus.result); end
        compared++; if (bus.hi !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_hi actual=%h required=0", bus.hi); end
        compared++; if (bus.zero !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_zero actual=%b required=1", bus.zero); end
        compared++; if (bus.illegal !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_illegal actual=%b required=0", bus.illegal); end
        compared++; if (bus.overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_overflow actual=%b required=0", bus.overflow); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        do_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
        compared++; if (bus.valid_out !== 1'b1) begin mismatched++; $display("[TB] FAIL add_valid actual=%b required=1", bus.valid_out); end
        compared++; if (bus.result !== 32'h8000_0000) begin mismatched++; $display("[TB] FAIL add_ovf_result actual=%h required=80000000", bus.result); end
        compared++; if (bus.zero !== 1'b0) begin mismatched++; $display("[TB] FAIL add_ovf_zero actual=%b required=0", bus.zero); end
        compared++; if (bus.overflow !== OVF_ON) begin mismatched++; $display("[TB] FAIL add_ovf_flag actual=%b required=%b", bus.overflow, OVF_ON); end
        @(posedge clk); #1;
        compared++; if (bus.valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL add_pulse actual=%b required=0", bus.valid_out); end
        compared++; if (bus.result !== 32'h8000_0000) begin mismatched++; $display("[TB] FAIL add_hold actual=%h required=80000000", bus.result); end
        do_op(ALU_ADD, 32'd3, 32'd4);
        compared++; if (bus.result !== 32'd7) begin mismatched++; $display("[TB] FAIL add_small actual=%h required=7", bus.result); end
        compared++; if (bus.overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL add_small_ovf actual=%b required=0", bus.overflow); end
        do_op(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
        compared++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin mismatched++; $display("[TB] FAIL add_wrap actual=%h/%b required=0/1", bus.result, bus.zero); end
        compared++; if (bus.overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL add_wrap_ovf actual=%b required=0", bus.overflow); end
    endtask

    task automatic test_sub_lui();
        do_op(ALU_SUB, 32'd5, 32'd5);
        compared++; if (bus.result !== 32'h0 || bus.zero !== 1'b1 || bus.hi !== 32'h0) begin mismatched++; $display("[TB] FAIL sub_eq actual=%h/%b/%h required=0/1/0", bus.result, bus.zero, bus.hi); end
        do_op(ALU_SUB, 32'h8000_0000, 32'h1);
        compared++; if (bus.result !== 32'h7FFF_FFFF) begin mismatched++; $display("[TB] FAIL sub_ovf_result actual=%h required=7fffffff", bus.result); end
        compared++; if (bus.overflow !== OVF_ON) begin mismatched++; $display("[TB] FAIL sub_ovf_flag actual=%b required=%b", bus.overflow, OVF_ON); end
        do_op(ALU_LUI, 32'h0, 32'h0000_1234);
        compared++; if (bus.result !== 32'h1234_0000) begin mismatched++; $display("[TB] FAIL lui actual=%h required=12340000", bus.result); end
        do_op(ALU_LUI, 32'h5, 32'hFFFF_ABCD);
        compared++; if (bus.result !== 32'hABCD_0000 || bus.hi !== 32'h0) begin mismatched++; $display("[TB] FAIL lui_upper actual=%h/%h required=abcd0000/0", bus.result, bus.hi); end
    endtask

    task automatic test_slti();
        do_op(ALU_SLTI, 32'hFFFF_FFFF, 32'h0);
        compared++; if (bus.result !== 32'h1) begin mismatched++; $display("[TB] FAIL slti_neg actual=%h required=1", bus.result); end
        do_op(ALU_SLTI, 32'h0, 32'hFFFF_FFFF);
        compared++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin mismatched++; $display("[TB] FAIL slti_pos actual=%h/%b required=0/1", bus.result, bus.zero); end
        do_op(ALU_SLTI, 32'h8000_0000, 32'h7FFF_FFFF);
        compared++; if (bus.result !== 32'h1) begin mismatched++; $display("[TB] FAIL slti_extreme actual=%h required=1", bus.result); end
        do_op(ALU_SLTI, 32'd5, 32'd5);
        compared++; if (bus.result !== 32'h0) begin mismatched++; $display("[TB] FAIL slti_equal actual=%h required=0", bus.result); end
    endtask

    task automatic test_mult();
        int   cycles;
        logic ready_seen;
        do_op(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_valid(cycles, ready_seen);
        compared++; if (cycles != 33) begin mismatched++; $display("[TB] FAIL mult_latency actual=%0d required=33", cycles); end
        compared++; if (ready_seen !== 1'b0) begin mismatched++; $display("[TB] FAIL mult_busy_ready actual=%b required=0", ready_seen); end
        compared++; if ({bus.hi, bus.result} !== 64'hFFFF_FFFF_FFFF_FFEB) begin mismatched++; $display("[TB] FAIL mult_neg actual=%h required=ffffffffffffffeb", {bus.hi, bus.result}); end
        do_op(ALU_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_valid(cycles, ready_seen);
        compared++; if ({bus.hi, bus.result} !== 64'h4000_0000_0000_0000) begin mismatched++; $display("[TB] FAIL mult_minsq actual=%h required=4000000000000000", {bus.hi, bus.result}); end
        compared++; if (bus.zero !== 1'b1) begin mismatched++; $display("[TB] FAIL mult_minsq_zero actual=%b required=1", bus.zero); end
        do_op(ALU_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_valid(cycles, ready_seen);
        compared++; if ({bus.hi, bus.result} !== 64'h3FFF_FFFF_0000_0001) begin mismatched++; $display("[TB] FAIL mult_maxsq actual=%h required=3fffffff00000001", {bus.hi, bus.result}); end
        do_op(ALU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(cycles, ready_seen);
        compared++; if ({bus.hi, bus.result} !== 64'h1 || bus.zero !== 1'b0) begin mismatched++; $display("[TB] FAIL mult_negneg actual=%h/%b required=1/0", {bus.hi, bus.result}, bus.zero); end
    endtask

    task automatic test_back_to_back();
        int n = 1;
        int pulses = 0;
        do_op(ALU_MULT, 32'd2, 32'd3);
        bus.valid_in = 1'b1;
        while (bus.valid_out !== 1'b1 && n < 100) begin
            @(negedge clk);
            bus.alu_control = n[0] ? ALU_ADD : ALU_SUB;
            bus.a = 32'd100 + 32'(n);
            @(posedge clk); #1;
            n++;
        end
        bus.valid_in = 1'b0;
        compared++; if (n != 33) begin mismatched++; $display("[TB] FAIL busy_ignore_latency actual=%0d required=33", n); end
        compared++; if (bus.result !== 32'd6 || bus.hi !== 32'h0) begin mismatched++; $display("[TB] FAIL busy_ignore_result actual=%h/%h required=6/0", bus.result, bus.hi); end
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.valid_out === 1'b1) pulses++;
        end
        compared++; if (pulses != 0) begin mismatched++; $display("[TB] FAIL busy_ignore_pulses actual=%0d required=0", pulses); end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        do_op(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        compared++; if (bus.ready !== 1'b1 || bus.valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_handshake actual=%b/%b required=1/0", bus.ready, bus.valid_out); end
        compared++; if (bus.result !== 32'h0 || bus.zero !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_result actual=%h/%b required=0/1", bus.result, bus.zero); end
        @(negedge clk);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.valid_out === 1'b1) seen++;
        end
        compared++; if (seen != 0) begin mismatched++; $display("[TB] FAIL abort_no_valid actual=%0d required=0", seen); end
    endtask

    task automatic test_illegal();
        int   cycles;
        logic ready_seen;
        do_op(ALU_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_valid(cycles, ready_seen);
        do_op(3'b011, 32'd1, 32'd2);
        compared++; if (bus.valid_out !== 1'b1 || bus.illegal !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_flag actual=%b/%b required=1/1", bus.valid_out, bus.illegal); end
        compared++; if (bus.result !== 32'h0 || bus.hi !== 32'h0 || bus.zero !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_outputs actual=%h/%h/%b required=0/0/1", bus.result, bus.hi, bus.zero); end
        do_op(3'b100, 32'h7FFF_FFFF, 32'd1);
        compared++; if (bus.illegal !== 1'b1 || bus.overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL illegal_100 actual=%b/%b required=1/0", bus.illegal, bus.overflow); end
        do_op(ALU_ADD, 32'd1, 32'd1);
        compared++; if (bus.illegal !== 1'b0 || bus.result !== 32'd2) begin mismatched++; $display("[TB] FAIL illegal_clear actual=%b/%h required=0/2", bus.illegal, bus.result); end
    endtask

    // The scenarios run in order. Each one leaves the unit idle or about to
    // become idle.
    initial begin
        bus.valid_in    = 1'b0;
        bus.alu_control = ALU_ADD;
        bus.a           = '0;
        bus.b           = '0;
        $display("[TB] start");
        test_reset();
        test_add();
        test_sub_lui();
        test_slti();
        test_mult();
        test_back_to_back();
        test_reset_abort();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
